// File: rtl/wptr_full_ctrl_if.sv
// Write-side bus of the async FIFO pointer/full controller.
// master : write requester and status consumer (drives winc, clr_ovf, wq2_rptr)
// slave  : wptr_full_ctrl (drives pointers, memory write controls and status)
interface wptr_full_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 6
);
  logic                  winc;
  logic [ADDR_WIDTH:0]   wq2_rptr;
  logic                  clr_ovf;
  logic [ADDR_WIDTH:0]   wptr;
  logic [ADDR_WIDTH-1:0] waddr;
  logic                  wen;
  logic                  wfull;
  logic                  walmost_full;
  logic [ADDR_WIDTH:0]   wlevel;
  logic                  woverflow;

  modport master (
    output winc, wq2_rptr, clr_ovf,
    input  wptr, waddr, wen, wfull, walmost_full, wlevel, woverflow
  );

  modport slave (
    input  winc, wq2_rptr, clr_ovf,
    output wptr, waddr, wen, wfull, walmost_full, wlevel, woverflow
  );
endinterface

// File: rtl/wptr_full_ctrl.sv
// Write-domain pointer and full-flag controller for the async FIFO.
// Owns the binary/Gray write pointers, drives the memory write address/enable,
// and derives full, almost-full, occupancy and sticky overflow from the read
// pointer already synchronized into this clock domain.
// Ports:
//   clk    write-domain clock
//   rst_n  asynchronous active-low reset
//   bus    slave side of wptr_full_ctrl_if (winc, wq2_rptr, clr_ovf in;
//          wptr, waddr, wen, wfull, walmost_full, wlevel, woverflow out)
module wptr_full_ctrl #(
  parameter int unsigned ADDR_WIDTH   = 6,
  parameter int unsigned AFULL_THRESH = 56
) (
  input  logic            clk,
  input  logic            rst_n,
  wptr_full_ctrl_if.slave bus
);

  localparam int unsigned A    = ADDR_WIDTH;
  localparam int unsigned PtrW = ADDR_WIDTH + 1;
  localparam logic [A:0]  AfullThr = PtrW'(AFULL_THRESH);

  logic [A:0] wbin_q, wbin_d;
  logic [A:0] wgray_q, wgray_d;
  logic [A:0] wlevel_q, wlevel_d;
  logic [A:0] rbin;
  logic       wfull_q, wfull_d;
  logic       walmost_full_q, walmost_full_d;
  logic       woverflow_q, woverflow_d;
  logic       wen;

  always_comb begin
    wen     = bus.winc & ~wfull_q;
    wbin_d  = wbin_q + {{A{1'b0}}, wen};
    wgray_d = (wbin_d >> 1) ^ wbin_d;

    // Gray-to-binary: bit i is the XOR of all Gray bits from the MSB down to i.
    rbin = '0;
    for (int i = 0; i <= int'(A); i++) begin
      rbin[i] = ^(bus.wq2_rptr >> i);
    end

    // Full when the next write pointer equals the read pointer with the two
    // MSBs inverted (Gray form of "one lap ahead"). Using next-state values
    // keeps wfull aligned with the write that fills the last slot.
    wfull_d = (wgray_d == {~bus.wq2_rptr[A:A-1], bus.wq2_rptr[A-2:0]});

    // Synchronizer lag only delays visibility of reads, so this never
    // under-reports stored entries.
    wlevel_d       = wbin_d - rbin;
    walmost_full_d = (wlevel_d >= AfullThr);

    // Set takes priority over clear.
    woverflow_d = woverflow_q;
    if (bus.clr_ovf) woverflow_d = 1'b0;
    if (bus.winc && wfull_q) woverflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbin_q         <= '0;
      wgray_q        <= '0;
      wlevel_q       <= '0;
      wfull_q        <= 1'b0;
      walmost_full_q <= 1'b0;
      woverflow_q    <= 1'b0;
    end else begin
      wbin_q         <= wbin_d;
      wgray_q        <= wgray_d;
      wlevel_q       <= wlevel_d;
      wfull_q        <= wfull_d;
      walmost_full_q <= walmost_full_d;
      woverflow_q    <= woverflow_d;
    end
  end

  assign bus.wptr         = wgray_q;
  assign bus.waddr        = wbin_q[A-1:0];
  assign bus.wen          = wen;
  assign bus.wfull        = wfull_q;
  assign bus.walmost_full = walmost_full_q;
  assign bus.wlevel       = wlevel_q;
  assign bus.woverflow    = woverflow_q;

endmodule

// File: doc/wptr_full_ctrl.md
# wptr_full_ctrl

Write-domain pointer and full-flag controller for the async FIFO. It sits directly upstream of the write-to-read pointer synchronizer. It owns the binary and Gray write pointers and drives the memory write address and enable. It consumes the read pointer after synchronization into the write clock domain, and from it generates the full, almost-full, occupancy and overflow status.

## Interface
- ADDR_WIDTH, 6, memory address width; FIFO depth = 2^ADDR_WIDTH (64).
- AFULL_THRESH, 56, occupancy at or above which walmost_full is asserted; legal range 1..2^ADDR_WIDTH.
- clk  in  1  write-domain clock.
- rst_n  in  1  reset, asynchronous, active-low.
- winc  in  1  write request for this cycle.
- wq2_rptr  in  ADDR_WIDTH+1  Gray read pointer, already double-synchronized into clk.
- clr_ovf  in  1  clears woverflow.
- wptr  out  ADDR_WIDTH+1  registered Gray write pointer, fed to the read-domain synchronizer.
- waddr  out  ADDR_WIDTH  binary write address to the memory (wbin[ADDR_WIDTH-1:0]).
- wen  out  1  memory write enable, combinational: winc & ~wfull.
- wfull  out  1  registered full flag.
- walmost_full  out  1  registered; wlevel >= AFULL_THRESH.
- wlevel  out  ADDR_WIDTH+1  registered occupancy, pessimistic (0..2^ADDR_WIDTH).
- woverflow  out  1  sticky; set when a write is attempted while full.

## Operation
- Internal wbin is ADDR_WIDTH+1 bits and wraps modulo 2^(ADDR_WIDTH+1).
- Next-state logic:
  - wbin_next = wbin + (winc & ~wfull).
  - wgray_next = (wbin_next >> 1) ^ wbin_next.
- Full detection:
  - wfull_next = (wgray_next == {~wq2_rptr[A:A-1], wq2_rptr[A-2:0]}), where A = ADDR_WIDTH.
  - Full is detected on next-state values, so wfull is never one cycle late.
- Occupancy:
  - rbin = Gray-to-binary of wq2_rptr, computed with an XOR prefix from the MSB.
  - wlevel_next = (wbin_next - rbin) mod 2^(A+1).
  - walmost_full_next = (wlevel_next >= AFULL_THRESH).
- Registered on every clk edge: wbin, wptr, wfull, wlevel, walmost_full.
- A write while full is dropped: wen = 0 and pointers hold.
- Overflow:
  - woverflow is set when winc & wfull.
  - woverflow is cleared by clr_ovf.
  - If set and clear occur in the same cycle, set wins.
- Status is pessimistic. Reads freeing slots become visible only after the synchronizer latency. The block never reports fewer entries than are actually stored.

## Timing
- Reset (asynchronous, immediate) values:
  - wbin, wptr, waddr, wlevel = 0.
  - wfull, walmost_full, woverflow = 0.
  - wen follows winc.
- Write acceptance:
  - A write is accepted at the rising edge when wen = 1.
  - waddr, wptr and wlevel reflect the accepted write after that edge.
- wfull asserts at the same edge that accepts the write filling the last slot. The next winc therefore sees wen = 0.
- wfull deasserts at the first edge after wq2_rptr advances. wlevel and walmost_full update at the same edge.
- Simultaneous write and wq2_rptr change: both are folded into wlevel_next. With one write in and one read seen, wlevel is unchanged.
- wptr changes at most one bit per clock. This is a requirement for the downstream synchronizer.
- wrap-around: wbin steps from 127 to 0. wptr steps from Gray(127) = 7'b1000000 to 7'b0000000. The full comparison remains correct across the wrap.
- Reset asserted mid-operation: all registers clear asynchronously. Operation restarts from an empty state on the first edge after rst_n deasserts. The read side is also required to be reset.

## Test plan
- Reset: rst_n low, winc = 1 → wptr = 0, waddr = 0, wlevel = 0, wfull = 0, woverflow = 0, wen = 1.
- Fill: wq2_rptr = 0, 64 back-to-back winc → walmost_full rises after the 56th write (wlevel = 56). After the 64th: wfull = 1, wlevel = 64, wptr = 7'b1100000, waddr = 0.
- Overflow: from full, winc for 3 cycles → wen = 0, wptr unchanged, woverflow = 1 and held. Then clr_ovf with winc = 0 → woverflow = 0. clr_ovf together with winc while full → woverflow stays 1.
- Free slot: from full, drive wq2_rptr = 7'b0000001 → after one edge wfull = 0, wlevel = 63, walmost_full = 1. One winc → wfull = 1 again.
- Wrap / streaming: 300 writes with wq2_rptr following Gray(wbin) delayed by 3 cycles → no wfull, wbin wraps twice, every wptr transition is a single-bit change, wlevel stays ≤ 4.
- Reset mid-run: at wlevel = 30, pulse rst_n low between edges → all outputs 0 immediately. After release, 1 write with wq2_rptr = 0 → wlevel = 1, wptr = 7'b0000001.
